// File: rtl/conv_window_reader.sv
// Walks a 3x3 stride-1 window over a row-major image in a 3-lane synchronous BRAM
// and presents each assembled window to the MAC stage over valid/ready.
module conv_window_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_PORTS  = 3,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic [ADDR_WIDTH-1:0]           i_base_addr,
    output logic [ADDR_WIDTH*RAM_PORTS-1:0] o_r_addrs,
    input  logic [RAM_WIDTH*RAM_PORTS-1:0]  i_data,
    output logic [RAM_WIDTH*9-1:0]          o_window,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [ADDR_WIDTH-1:0]           o_row,
    output logic [ADDR_WIDTH-1:0]           o_col,
    output logic                            o_busy,
    output logic                            o_done
);
    localparam int ROW_BITS = RAM_WIDTH * 3;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_W - 3);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(IMG_H - 3);

    typedef enum logic [2:0] {IDLE, A0, A1, A2, CAP, VLD, DONE} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   tl_reg;
    logic                    col_wrap;
    logic                    last_window;
    logic [ADDR_WIDTH-1:0]   next_tl;

    // Three consecutive addresses of window row k, wrapping modulo the address space.
    function automatic logic [ADDR_WIDTH*3-1:0] row_addrs(input logic [ADDR_WIDTH-1:0] tl,
                                                          input int k);
        logic [ADDR_WIDTH-1:0] a;
        a = tl + ADDR_WIDTH'(k * IMG_W);
        return {a + ADDR_WIDTH'(2), a + ADDR_WIDTH'(1), a};
    endfunction

    assign col_wrap    = (o_col == LAST_COL);
    assign last_window = col_wrap && (o_row == LAST_ROW);
    // Moving from the last column to the next row's first column advances tl by exactly 3.
    assign next_tl     = tl_reg + (col_wrap ? ADDR_WIDTH'(3) : ADDR_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            tl_reg    <= '0;
            o_r_addrs <= '0;
            o_window  <= '0;
            o_valid   <= 1'b0;
            o_row     <= '0;
            o_col     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        state_reg <= A0;
                        tl_reg    <= i_base_addr;
                        o_r_addrs <= row_addrs(i_base_addr, 0);
                        o_row     <= '0;
                        o_col     <= '0;
                        o_busy    <= 1'b1;
                    end
                end
                A0: begin
                    o_r_addrs <= row_addrs(tl_reg, 1);
                    state_reg <= A1;
                end
                A1: begin
                    o_window[0 +: ROW_BITS] <= i_data;
                    o_r_addrs <= row_addrs(tl_reg, 2);
                    state_reg <= A2;
                end
                A2: begin
                    o_window[ROW_BITS +: ROW_BITS] <= i_data;
                    state_reg <= CAP;
                end
                CAP: begin
                    o_window[2*ROW_BITS +: ROW_BITS] <= i_data;
                    o_valid   <= 1'b1;
                    state_reg <= VLD;
                end
                VLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (last_window) begin
                            o_done    <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            tl_reg    <= next_tl;
                            o_r_addrs <= row_addrs(next_tl, 0);
                            state_reg <= A0;
                            if (col_wrap) begin
                                o_col <= '0;
                                o_row <= o_row + ADDR_WIDTH'(1);
                            end else begin
                                o_col <= o_col + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    o_done    <= 1'b0;
                    o_busy    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/conv_window_reader.md
# conv_window_reader

Read-side initiator for the multi-port `bram` in the convolution datapath. After a start pulse it walks a 3x3, stride-1 window over an IMG_W x IMG_H image stored row-major in the BRAM. For each window it issues three 3-lane row reads and assembles the nine pixels into one packed matrix word. It presents that word to the MAC stage over a valid/ready handshake.

## Interface
- ADDR_WIDTH, 6: BRAM address width.
- RAM_WIDTH, 8: pixel width.
- RAM_PORTS, 3: BRAM read lanes; fixed at 3, one window row per read.
- IMG_W, 8: image width in pixels, minimum 3.
- IMG_H, 8: image height in pixels, minimum 3.

- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start-of-image pulse; ignored while o_busy=1.
- i_base_addr  in  ADDR_WIDTH  address of pixel (0,0); sampled on the accepted i_start.
- o_r_addrs  out  ADDR_WIDTH*RAM_PORTS  registered; drives BRAM i_r_addrs; lane k is bits [ADDR_WIDTH*(k+1)-1 : ADDR_WIDTH*k].
- i_data  in  RAM_WIDTH*RAM_PORTS  BRAM o_data; lane k returns lane k's address.
- o_window  out  RAM_WIDTH*9  window; row r, lane k is at bits [RAM_WIDTH*(3r+k+1)-1 : RAM_WIDTH*(3r+k)].
- o_valid  out  1  o_window valid.
- i_ready  in  1  consumer accepts o_window.
- o_row, o_col  out  ADDR_WIDTH  top-left coordinate of the current window.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last window is accepted.

## Operation
- BRAM read is synchronous. An address on o_r_addrs at rising edge E appears on i_data after E and is captured at edge E+1.
- The top-left address is tl = base + row*IMG_W + col. The address of row k is {tl+k*IMG_W+2, tl+k*IMG_W+1, tl+k*IMG_W}, all computed modulo 2^ADDR_WIDTH (wrap allowed).
- Scan order: col is the inner loop, 0..IMG_W-3; row is the outer loop, 0..IMG_H-3. The block produces (IMG_W-2)*(IMG_H-2) windows.
- FSM states:
  - IDLE:
    - i_start → A0.
    - Latch the base.
    - Load o_r_addrs with row 0.
    - Clear row and col.
  - A0:
    - → A1.
    - Load o_r_addrs with row 1.
  - A1:
    - → A2.
    - Capture i_data into window row 0.
    - Load o_r_addrs with row 2.
  - A2:
    - → CAP.
    - Capture window row 1.
  - CAP:
    - → VLD.
    - Capture window row 2.
    - Set o_valid=1.
  - VLD, with o_valid=1 and o_window, o_row, o_col held stable:
    - No handshake (i_ready=0) → stay in VLD.
    - Handshake, not the last window → A0. Clear o_valid. Advance col; if col wraps, reset col to 0 and increment row. Load o_r_addrs with row 0 of the next window.
    - Handshake, last window → DONE. Clear o_valid.
  - DONE:
    - Pulse o_done=1.
    - → IDLE.
- i_start is ignored in every state except IDLE. An i_start in the same cycle as o_done is also ignored.
- o_r_addrs holds its last value in VLD, DONE and IDLE.

## Timing
- Reset values: state IDLE; o_r_addrs=0, o_window=0, o_valid=0, o_row=0, o_col=0, o_busy=0, o_done=0.
- Asserting reset mid-operation aborts immediately to reset values. o_done does not pulse.
- Latency: i_start accepted at edge E0 → o_valid high after edge E0+4.
- Window period with i_ready held high: 5 cycles.
- o_busy rises after the start edge and falls after the DONE cycle.

## Test plan
- BRAM preloaded with mem[n]=n+1; base=0; IMG 8x8; i_ready=1; pulse i_start:
  - o_valid rises 4 cycles after the start edge.
  - First o_window = 0x13_12_11_0B_0A_09_03_02_01 (pixels 1,2,3 / 9,10,11 / 17,18,19).
  - Second window = 0x14_13_12_0C_0B_0A_04_03_02.
- Same setup, full run:
  - Exactly 36 windows in raster order; the last is row=5, col=5 = 0x40_3F_3E_38_37_36_30_2F_2E.
  - o_done pulses once, 1 cycle after the final handshake; o_busy then falls.
  - The run takes 36*5+1 cycles.
- Backpressure:
  - Hold i_ready=0 for 7 cycles on window 3 → o_valid and o_window stable, no extra BRAM address change.
  - Release → window 4 begins.
- Wrap: base=60 → first window's row-1 addresses = {6,5,4}, row-0 addresses = {62,61,60}.
- i_start pulsed while busy → ignored; window count and order unchanged.
- Reset asserted in state A2 mid-image:
  - All outputs return to 0, no o_done.
  - A new i_start then restarts from row=0, col=0 with correct data.
